// File: rtl/simd_en_stack.sv
// simd_en_stack: per-lane enable-mask stack plus shared call/return-address stack (optional ENSTACK_CALL_WRAP_EN: CALL on full stack drops oldest entry)
module simd_en_stack #(
  parameter int NPROC  = 20,
  parameter int EDEPTH = 8,
  parameter int CDEPTH = 4,
  parameter int AW     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [NPROC-1:0] cond,
  input  logic [AW-1:0]    ret_addr,
  input  logic             err_clr,
  output logic [NPROC-1:0] en_mask,
  output logic             any_en,
  output logic [5:0]       en_depth,
  output logic             call_taken,
  output logic             ret_valid,
  output logic [AW-1:0]    ret_pc,
  output logic             err_eovf,
  output logic             err_eunf,
  output logic             err_covf,
  output logic             err_cunf
);
  localparam int SW = (EDEPTH + 1) * NPROC;
  localparam int CS = CDEPTH * AW;
  logic [SW-1:0]    stk, stk_n;
  logic [CS-1:0]    cstk, cstk_n;
  logic [4:0]       cdep, cdep_n;
  logic [5:0]       dep_n;
  logic [NPROC-1:0] top, below, nmask;
  logic [AW-1:0]    pop_addr;
  logic             push, pop, els, all, ca, rt, efull, cfull;
  logic             call_ok, ret_ok, eovf, eunf, covf, cunf;
  int               d, ri;
  // next-state of both stacks; level 0 is the base and is itself writable by ELSEEN/ALLEN
  always_comb begin
    d      = int'(en_depth);
    top    = stk[d*NPROC +: NPROC];
    below  = (d == 0) ? '1 : stk[((d == 0) ? 0 : d - 1)*NPROC +: NPROC];
    push   = op_valid && op == 3'd1;
    pop    = op_valid && op == 3'd2;
    all    = op_valid && op == 3'd3;
    els    = op_valid && op == 3'd4;
    ca     = op_valid && op == 3'd5 && any_en;
    rt     = op_valid && op == 3'd6 && any_en;
    efull  = en_depth == 6'(EDEPTH);
    eovf   = push && efull;
    eunf   = pop && d == 0;
    stk_n  = stk;
    dep_n  = en_depth;
    if (push && !efull) begin
      stk_n[(d + 1)*NPROC +: NPROC] = top & cond;
      dep_n = en_depth + 6'd1;
    end
    if (pop && d != 0) dep_n = en_depth - 6'd1;
    if (els) stk_n[d*NPROC +: NPROC] = (d == 0) ? ~top : below & ~top;
    if (all) stk_n[d*NPROC +: NPROC] = below;
    nmask  = stk_n[int'(dep_n)*NPROC +: NPROC];
    cfull  = cdep == 5'(CDEPTH);
`ifdef ENSTACK_CALL_WRAP_EN
    call_ok = ca;
    covf    = 1'b0;
`else
    call_ok = ca && !cfull;
    covf    = ca && cfull;
`endif
    ret_ok   = rt && cdep != 5'd0;
    cunf     = rt && cdep == 5'd0;
    ri       = (cdep == 5'd0) ? 0 : int'(cdep) - 1;
    pop_addr = cstk[ri*AW +: AW];
    cstk_n   = cstk;
    cdep_n   = cdep;
    if (call_ok && cfull) begin
      cstk_n = cstk >> AW;
      cstk_n[(CDEPTH - 1)*AW +: AW] = ret_addr;
    end else if (call_ok) begin
      cstk_n[int'(cdep)*AW +: AW] = ret_addr;
      cdep_n = cdep + 5'd1;
    end
    if (ret_ok) cdep_n = cdep - 5'd1;
  end
  // register stack state, outputs and sticky errors (a set beats a same-cycle clear)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stk        <= '1;
      en_depth   <= '0;
      cstk       <= '0;
      cdep       <= '0;
      en_mask    <= '1;
      any_en     <= 1'b1;
      call_taken <= 1'b0;
      ret_valid  <= 1'b0;
      ret_pc     <= '0;
      err_eovf   <= 1'b0;
      err_eunf   <= 1'b0;
      err_covf   <= 1'b0;
      err_cunf   <= 1'b0;
    end else begin
      stk        <= stk_n;
      en_depth   <= dep_n;
      cstk       <= cstk_n;
      cdep       <= cdep_n;
      en_mask    <= nmask;
      any_en     <= |nmask;
      call_taken <= call_ok;
      ret_valid  <= ret_ok;
      if (ret_ok) ret_pc <= pop_addr;
      err_eovf   <= eovf | (err_eovf & ~err_clr);
      err_eunf   <= eunf | (err_eunf & ~err_clr);
      err_covf   <= covf | (err_covf & ~err_clr);
      err_cunf   <= cunf | (err_cunf & ~err_clr);
    end
  end
endmodule

// File: tb/tb_simd_en_stack.sv
// tb_simd_en_stack: queue-based reference model, directed plan plus random ops
module tb_simd_en_stack;
  localparam int NPROC = 4, EDEPTH = 2, CDEPTH = 2, AW = 16;
  logic clk = 0, reset = 0, op_valid = 0, err_clr = 0;
  logic [2:0] op = 0;
  logic [NPROC-1:0] cond = 0, en_mask;
  logic [AW-1:0] ret_addr = 0, ret_pc;
  logic [5:0] en_depth;
  logic any_en, call_taken, ret_valid, err_eovf, err_eunf, err_covf, err_cunf;
  int n_chk = 0, n_pass = 0;
  logic [NPROC-1:0] q[$];
  logic [AW-1:0] cs[$];
  logic [AW-1:0] m_pc;
  logic m_ct, m_rv;
  logic [3:0] m_err;

  simd_en_stack #(.NPROC(NPROC), .EDEPTH(EDEPTH), .CDEPTH(CDEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .cond(cond),
    .ret_addr(ret_addr), .err_clr(err_clr), .en_mask(en_mask), .any_en(any_en),
    .en_depth(en_depth), .call_taken(call_taken), .ret_valid(ret_valid),
    .ret_pc(ret_pc), .err_eovf(err_eovf), .err_eunf(err_eunf),
    .err_covf(err_covf), .err_cunf(err_cunf));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    q = {4'hF};
    cs = {};
    m_pc = 0; m_ct = 0; m_rv = 0; m_err = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".en_mask"}, 32'(en_mask), 32'(q[$]));
    chk({tag, ".any_en"}, 32'(any_en), 32'(|q[$]));
    chk({tag, ".en_depth"}, 32'(en_depth), 32'(q.size() - 1));
    chk({tag, ".call_taken"}, 32'(call_taken), 32'(m_ct));
    chk({tag, ".ret_valid"}, 32'(ret_valid), 32'(m_rv));
    chk({tag, ".ret_pc"}, 32'(ret_pc), 32'(m_pc));
    chk({tag, ".err"}, 32'({err_eovf, err_eunf, err_covf, err_cunf}), 32'(m_err));
  endtask

  task automatic step(input string tag, input logic v, input logic [2:0] o,
                      input logic [NPROC-1:0] c, input logic [AW-1:0] a, input logic clr);
    logic [3:0] s;
    logic ae;
    op_valid = v; op = o; cond = c; ret_addr = a; err_clr = clr;
    s = 0; m_ct = 0; m_rv = 0;
    ae = |q[$];
    if (v) begin
      if (o == 1) begin
        if (q.size() == EDEPTH + 1) s[3] = 1; else q.push_back(q[$] & c);
      end else if (o == 2) begin
        if (q.size() == 1) s[2] = 1; else void'(q.pop_back());
      end else if (o == 3) begin
        q[$] = (q.size() > 1) ? q[$-1] : 4'hF;
      end else if (o == 4) begin
        q[$] = (q.size() > 1) ? (q[$-1] & ~q[$]) : ~q[$];
      end else if (o == 5 && ae) begin
        if (cs.size() < CDEPTH) begin cs.push_back(a); m_ct = 1; end
        else begin
`ifdef ENSTACK_CALL_WRAP_EN
          void'(cs.pop_front()); cs.push_back(a); m_ct = 1;
`else
          s[1] = 1;
`endif
        end
      end else if (o == 6 && ae) begin
        if (cs.size() > 0) begin m_pc = cs.pop_back(); m_rv = 1; end
        else s[0] = 1;
      end
    end
    if (clr) m_err = 0;
    m_err |= s;
    @(posedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset_held");
    reset = 1;
    @(posedge clk); #1 check_all("reset_rel");
    step("push0101", 1, 1, 4'b0101, 0, 0);
    chk("plan.push_mask", 32'(en_mask), 32'h5);
    step("else", 1, 4, 0, 0, 0);
    chk("plan.else_mask", 32'(en_mask), 32'hA);
    step("pop", 1, 2, 0, 0, 0);
    chk("plan.pop_mask", 32'(en_mask), 32'hF);
    for (int i = 0; i < 3; i++) step("push_ovf", 1, 1, 4'hF, 0, 0);
    chk("plan.eovf", 32'(err_eovf), 32'd1);
    for (int i = 0; i < 3; i++) step("pop_unf", 1, 2, 0, 0, 0);
    chk("plan.eunf", 32'(err_eunf), 32'd1);
    step("clr", 0, 0, 0, 0, 1);
    step("call10", 1, 5, 0, 16'h0010, 0);
    step("call20", 1, 5, 0, 16'h0020, 0);
    step("ret1", 1, 6, 0, 0, 0);
    chk("plan.ret1_pc", 32'(ret_pc), 32'h20);
    step("ret2", 1, 6, 0, 0, 0);
    chk("plan.ret2_pc", 32'(ret_pc), 32'h10);
    step("ret3", 1, 6, 0, 0, 0);
    chk("plan.cunf", 32'(err_cunf), 32'd1);
    step("nop", 1, 7, 0, 0, 1);
    step("push0000", 1, 1, 4'h0, 0, 0);
    step("call_off", 1, 5, 0, 16'h0030, 0);
    step("ret_off", 1, 6, 0, 0, 0);
    step("pop_on", 1, 2, 0, 0, 0);
    step("callA", 1, 5, 0, 16'h1, 0);
    step("callB", 1, 5, 0, 16'h2, 0);
    step("callC", 1, 5, 0, 16'h3, 0);
    step("retA", 1, 6, 0, 0, 0);
    step("retB", 1, 6, 0, 0, 0);
    step("retC", 1, 6, 0, 0, 1);
    for (int i = 0; i < 500; i++) begin
      step("rand", $urandom_range(0, 9) != 0, 3'($urandom_range(0, 7)),
           NPROC'($urandom), AW'($urandom), $urandom_range(0, 9) == 0);
      if (i == 250) begin
        #2 reset = 0;
        #1 model_reset();
        check_all("async_rst");
        #3 reset = 1;
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/simd_en_stack.md
Name: simd_en_stack

Overview:
- Parametrised per-lane enable-mask stack and shared call/return-address stack for the SIMD control engine.
- Generalises the single 32-bit enable register and the fixed 4-entry 64-bit call stack.
- Sits beside the control pipeline's stage-1 (ALU) decode and consumes pushen/popen/allen/else/call/ret operations.
- Drives a per-PE enable mask to the NPROC processing elements and supplies return addresses to the PC select.

Parameters:
- NPROC, 20, number of processing-element lanes (1..64).
- EDEPTH, 8, enable-stack nesting levels above the base level (1..32).
- CDEPTH, 4, call-stack entries (1..16).
- AW, 16, return-address width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- op_valid  input  1  op is presented this cycle.
- op  input  3  0 NOP, 1 PUSHEN, 2 POPEN, 3 ALLEN, 4 ELSEEN, 5 CALL, 6 RET, 7 NOP.
- cond  input  NPROC  per-lane condition (lane register nonzero).
- ret_addr  input  AW  address pushed by CALL (caller PC+1).
- err_clr  input  1  clears sticky error flags.
- en_mask  output  NPROC  current top-of-stack enable per lane.
- any_en  output  1  OR of en_mask.
- en_depth  output  6  current enable nesting level, 0..EDEPTH.
- call_taken  output  1  1-cycle pulse: CALL accepted.
- ret_valid  output  1  1-cycle pulse: ret_pc is valid.
- ret_pc  output  AW  popped return address, held until the next RET.
- err_eovf, err_eunf, err_covf, err_cunf  output  1 each  sticky enable-stack overflow/underflow and call-stack overflow/underflow.

Behaviour:
- All state updates occur on posedge clk when op_valid=1. op_valid=0 or op 0/7 leaves state unchanged.
- Reset asserted (reset=0), asynchronous, any cycle including mid-operation:
  - every lane stack becomes all 1s; en_depth=0; call depth=0.
  - en_mask all 1s, any_en=1, call_taken=0, ret_valid=0, ret_pc=0, all err_* =0.
- Enable stack is per lane, EDEPTH+1 bits. Level 0 is the base. top_i is level en_depth; below_i is level en_depth-1.
- PUSHEN:
  - en_depth<EDEPTH: new level = top_i & cond_i; en_depth+1.
  - en_depth==EDEPTH: no change; err_eovf<=1.
- POPEN:
  - en_depth>0: en_depth-1. Popped level contents are don't-care; next push overwrites.
  - en_depth==0: no change; err_eunf<=1.
- ELSEEN:
  - en_depth>0: top_i <= below_i & ~top_i.
  - en_depth==0: top_i <= ~top_i; no error.
- ALLEN: top_i <= below_i for every lane (1 at depth 0); depth unchanged.
- CALL (only if any_en=1):
  - call depth<CDEPTH: push ret_addr; depth+1; call_taken=1 next cycle.
  - full: no push; err_covf<=1; call_taken=0.
  - any_en=0: ignored, no error, call_taken=0.
- RET (only if any_en=1):
  - depth>0: pop; ret_pc<=entry; ret_valid=1 next cycle.
  - depth==0: err_cunf<=1; ret_valid=0; ret_pc holds.
  - any_en=0: ignored.
- Latency: en_mask, any_en, en_depth, call_taken, ret_valid and ret_pc are registered and reflect an op one cycle after its clock edge. Back-to-back ops every cycle are supported.
- Error flags: sticky until err_clr=1. If set and clear occur in the same cycle, set wins.
- Enable state is never modified by CALL/RET; call state is never modified by enable ops.

Optional Feature:
- Macro ENSTACK_CALL_WRAP_EN.
- Defined: CALL on a full call stack discards the oldest entry and pushes ret_addr. Depth stays CDEPTH, call_taken=1, err_covf is never set.
- Undefined: overflow behaviour as in Behaviour (no push, err_covf).

Test Plan:
- NPROC=4, reset low then high → en_mask=4'b1111, any_en=1, en_depth=0, all err=0, ret_pc=0.
- PUSHEN cond=4'b0101 → en_mask=0101, depth 1. ELSEEN → en_mask=1010. POPEN → en_mask=1111, depth 0.
- EDEPTH=2: PUSHEN ×3 (cond=1111) → depth 2, err_eovf=1, mask 1111. POPEN ×3 → depth 0, err_eunf=1. err_clr → both flags 0.
- CALL ret_addr=16'h0010 then 16'h0020, RET, RET → ret_pc=0020 then 0010, each with ret_valid 1-cycle pulse. Third RET → err_cunf=1, ret_pc stays 0010.
- PUSHEN cond=0000 (any_en=0), CALL ret_addr=16'h0030 → call_taken=0, call depth unchanged, no error. POPEN → any_en=1.
- CDEPTH=2, ENSTACK_CALL_WRAP_EN defined, CALL 1,2,3 then RET,RET → ret_pc 3 then 2, err_covf=0. Macro undefined → third CALL sets err_covf, RETs give 2 then 1.
